// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the UART TX arbiter
package uart_pkg;

    localparam int FIFO_EMPTY = 0;
    localparam int FIFO_AFULL = 1;
    localparam int FIFO_FULL  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker, first request after ptr wins
module uart_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid,
    output logic [PTR_W-1:0]   grant_idx
);

    always_comb begin
        int best;
        int rank;
        grant     = '0;
        valid     = 1'b0;
        grant_idx = '0;
        best      = NUM_REQ;
        rank      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // distance from ptr+1, wrapping at NUM_REQ (not at 2**PTR_W)
            rank = (i > int'(ptr)) ? (i - int'(ptr) - 1) : (i + NUM_REQ - int'(ptr) - 1);
            if (req[i] && (rank < best)) begin
                best      = rank;
                grant     = '0;
                grant[i]  = 1'b1;
                valid     = 1'b1;
                grant_idx = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, burst-limited sharing of the UART TX FIFO write port
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           fwdata,
    output logic                 fwrite,
    input  logic [3:0]           fwstatus,
    output logic                 busy
);

    localparam int         PTR_W       = $clog2(NUM_REQ);
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               fwrite_q, fwrite_d;
    logic [7:0]         fwdata_q, fwdata_d;
    logic               busy_q, busy_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [7:0]         burst_q, burst_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic               owner_req;
    logic [7:0]         owner_byte;
    logic               stall;
    logic               rel;
    logic               unused_status;

    assign unused_status = ^{fwstatus[FIFO_EMPTY], fwstatus[3]};

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (pick_grant),
        .valid     (pick_valid),
        .grant_idx (pick_idx)
    );

    always_comb begin
        owner_req  = |(req & grant_q);
        owner_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_byte = req_data[i*8 +: 8];
            end
        end
    end

    // Status lags one cycle: right after a write, almost-full is treated as full.
    assign stall = fwstatus[FIFO_FULL] || (fwrite_q && fwstatus[FIFO_AFULL]);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ack_d    = '0;
        fwrite_d = 1'b0;
        fwdata_d = fwdata_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        burst_d  = burst_q;
        rel      = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (pick_valid) begin
                    state_d = XFER;
                    grant_d = pick_grant;
                    owner_d = pick_idx;
                    burst_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                // The ack cycle is not a sampling cycle: the requester is still updating req/data.
                if (fwrite_q) begin
                    if (burst_q == BURST_LIMIT) begin
                        rel = 1'b1;
                    end
                end else if (!owner_req) begin
                    rel = 1'b1;
                end else if (!stall) begin
                    fwrite_d = 1'b1;
                    fwdata_d = owner_byte;
                    ack_d    = grant_q;
                    burst_d  = burst_q + 8'd1;
                end
                if (rel) begin
                    state_d = ARB;
                    grant_d = '0;
                    ptr_d   = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ack_q    <= '0;
            fwrite_q <= 1'b0;
            fwdata_q <= 8'h00;
            busy_q   <= 1'b0;
            ptr_q    <= PTR_W'(NUM_REQ - 1);
            owner_q  <= '0;
            burst_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            fwrite_q <= fwrite_d;
            fwdata_q <= fwdata_d;
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
        end
    end

    assign grant  = grant_q;
    assign ack    = ack_q;
    assign fwrite = fwrite_q;
    assign fwdata = fwdata_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and random bench for uart_tx_arbiter against a queue/phase model
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic [7:0]     fwdata;
    logic           fwrite;
    logic [3:0]     fwstatus;
    logic           busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .grant    (grant),
        .fwdata   (fwdata),
        .fwrite   (fwrite),
        .fwstatus (fwstatus),
        .busy     (busy)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] rq [N][$];
    int         wlog_own[$];
    logic [7:0] wlog_dat[$];
    int         bursts[$];
    int         phase, owner, last_owner, burst_n;
    int         fifo_cnt, fifo_max, pop_mod;
    logic [N-1:0] prev_req;
    logic [3:0] prev_status;
    logic       prev_fwrite;
    logic       force_en, mon_en;
    logic [3:0] force_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [3:0] stat(input int c);
        return {1'b0, c >= 8, c >= 7, c == 0};
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += rq[i].size();
        return s;
    endfunction

    task automatic model_reset();
        phase = 0; owner = 0; last_owner = N - 1; burst_n = 0;
        prev_fwrite = 1'b0; fifo_cnt = 0;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req[i] = (rq[i].size() > 0);
            req_data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
        end
    endtask

    // phases: 0 idle, 1 arbitrate, 2 transfer
    task automatic monitor();
        int nph, exp_owner, old;
        logic exp_fw;
        logic [N-1:0] exp_grant;
        nph = phase; exp_owner = owner; exp_fw = 1'b0;
        case (phase)
            0: nph = (prev_req != 0) ? 1 : 0;
            1: begin
                exp_owner = rr_pick(prev_req, last_owner);
                nph = (exp_owner >= 0) ? 2 : 0;
            end
            default: begin
                if (prev_fwrite) begin
                    if (burst_n == MB) nph = 1;
                end else if (!prev_req[owner]) begin
                    nph = 1;
                end else begin
                    exp_fw = !prev_status[2] && !(prev_fwrite && prev_status[1]);
                end
            end
        endcase
        exp_grant = '0;
        if (nph == 2) exp_grant[exp_owner] = 1'b1;
        chk("grant", grant, exp_grant);
        chk("busy", busy, nph != 0);
        chk("fwrite", fwrite, exp_fw);
        chk("ack", ack, exp_fw ? exp_grant : '0);
        chk("no_b2b_write", fwrite && prev_fwrite, 0);
        if (exp_fw) begin
            chk("fwdata", fwdata, rq[owner][0]);
            wlog_own.push_back(owner);
            wlog_dat.push_back(rq[owner][0]);
            void'(rq[owner].pop_front());
            burst_n++;
        end
        if (phase == 2 && nph != 2) begin
            bursts.push_back(burst_n);
            last_owner = owner;
        end
        if (phase != 2 && nph == 2) begin
            owner = exp_owner;
            burst_n = 0;
        end
        phase = nph;
        old = fifo_cnt;
        if (fwrite) fifo_cnt++;
        chk("fifo_overflow", fifo_cnt > 8, 0);
        if (fifo_cnt > fifo_max) fifo_max = fifo_cnt;
        if (pop_mod == 0) fifo_cnt = 0;
        else if (fifo_cnt > 0 && $urandom_range(pop_mod - 1) == 0) fifo_cnt--;
        fwstatus = force_en ? force_val : stat(old);
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_en) monitor();
        drive_reqs();
        prev_req = req;
        prev_status = fwstatus;
        prev_fwrite = fwrite;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int c = 0;
        while ((pending() > 0 || busy) && c < maxc) begin
            tick();
            c++;
        end
        chk({tag, "_timeout"}, c < maxc, 1);
    endtask

    task automatic clear_logs();
        wlog_own.delete(); wlog_dat.delete(); bursts.delete();
    endtask

    initial begin
        int n0, c, pushed, cnt1;
        logic [7:0] exp_bytes[3];
        reset_n = 1'b0; req = '0; req_data = '0; fwstatus = 4'b0001;
        force_en = 1'b0; force_val = 4'b0000; pop_mod = 0; mon_en = 1'b0; fifo_max = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_ack", ack, 0);
        chk("rst_fwrite", fwrite, 0);
        chk("rst_fwdata", fwdata, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        prev_req = req; prev_status = fwstatus; prev_fwrite = 1'b0; mon_en = 1'b1;

        // single requester
        clear_logs();
        exp_bytes[0] = 8'h41; exp_bytes[1] = 8'h42; exp_bytes[2] = 8'h43;
        for (int i = 0; i < 3; i++) rq[0].push_back(exp_bytes[i]);
        wait_done("single", 40);
        chk("single_count", wlog_dat.size(), 3);
        for (int i = 0; i < 3 && i < wlog_dat.size(); i++) begin
            chk("single_byte", wlog_dat[i], exp_bytes[i]);
            chk("single_owner", wlog_own[i], 0);
        end
        chk("single_idle", busy, 0);

        // contention: pointer now at 0, so requester 1 goes first
        clear_logs();
        for (int i = 0; i < 12; i++) begin
            rq[0].push_back(8'($urandom));
            rq[1].push_back(8'($urandom));
        end
        wait_done("contend", 200);
        chk("contend_count", wlog_own.size(), 24);
        for (int k = 0; k < 24 && k < wlog_own.size(); k++)
            chk("contend_order", wlog_own[k], ((k / 4) % 2 == 0) ? 1 : 0);
        for (int k = 0; k < bursts.size(); k++) chk("contend_burst", bursts[k], MB);

        // full stall mid-burst
        clear_logs();
        for (int i = 0; i < 6; i++) rq[0].push_back(8'($urandom));
        c = 0;
        while (wlog_own.size() < 2 && c < 40) begin tick(); c++; end
        chk("stall_reach_timeout", c < 40, 1);
        force_en = 1'b1; force_val = 4'b0100; fwstatus = force_val; prev_status = fwstatus;
        n0 = wlog_own.size();
        repeat (6) tick();
        chk("stall_no_write", wlog_own.size(), n0);
        chk("stall_grant_held", grant, 3'b001);
        force_en = 1'b0;
        wait_done("stall", 60);
        chk("stall_count", wlog_own.size(), 6);
        chk("stall_nbursts", bursts.size(), 2);
        if (bursts.size() == 2) begin
            chk("stall_burst0", bursts[0], 4);
            chk("stall_burst1", bursts[1], 2);
        end

        // almost-full gap against a slowly draining depth-8 FIFO
        clear_logs();
        pop_mod = 4; fifo_max = 0;
        for (int i = 0; i < 20; i++) rq[0].push_back(8'($urandom));
        wait_done("afull", 400);
        chk("afull_count", wlog_own.size(), 20);
        chk("afull_peak_ok", fifo_max <= 8, 1);
        chk("afull_pressure", fifo_max >= 6, 1);
        pop_mod = 0;
        repeat (2) tick();

        // early release: requester 1 has only 2 bytes, pointer at 0
        clear_logs();
        rq[1].push_back(8'h11); rq[1].push_back(8'h12);
        for (int i = 0; i < 3; i++) rq[0].push_back(8'h20 + 8'(i));
        wait_done("early", 60);
        chk("early_count", wlog_own.size(), 5);
        cnt1 = 0;
        for (int k = 0; k < wlog_own.size(); k++) begin
            if (wlog_own[k] == 1) cnt1++;
            chk("early_order", wlog_own[k], (k < 2) ? 1 : 0);
        end
        chk("early_acks1", cnt1, 2);

        // random traffic with FIFO back-pressure
        clear_logs();
        pop_mod = 3; pushed = 0;
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) begin
                    int nb = $urandom_range(1, 3);
                    for (int b = 0; b < nb; b++) rq[i].push_back(8'($urandom));
                    pushed += nb;
                end
            end
            tick();
        end
        wait_done("random", 3000);
        chk("random_count", wlog_own.size(), pushed);
        pop_mod = 0;
        repeat (2) tick();

        // reset mid-burst
        clear_logs();
        for (int i = 0; i < 6; i++) rq[2].push_back(8'h60 + 8'(i));
        c = 0;
        while (wlog_own.size() < 3 && c < 60) begin tick(); c++; end
        chk("rstmid_reach_timeout", c < 60, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_grant", grant, 0);
        chk("rstmid_fwrite", fwrite, 0);
        chk("rstmid_ack", ack, 0);
        chk("rstmid_busy", busy, 0);
        mon_en = 1'b0;
        model_reset();
        fwstatus = 4'b0001;
        rq[0].push_back(8'h01); rq[0].push_back(8'h02);
        clear_logs();
        repeat (2) tick();
        reset_n = 1'b1;
        prev_req = req; prev_status = fwstatus; prev_fwrite = 1'b0; mon_en = 1'b1;
        wait_done("rstmid", 80);
        chk("rstmid_count", wlog_own.size(), 5);
        if (wlog_own.size() == 5) begin
            chk("rstmid_first_owner", wlog_own[0], 0);
            chk("rstmid_resume_byte", wlog_dat[2], 8'h63);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
